// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Holds a double-buffered frame of hex digits; new frames are swapped in only at frame boundaries.
module sevenseg_scan #(
  parameter int N_DIGITS = 4,
  parameter int REFRESH  = 50000,
  parameter int BLANK    = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  // state | meaning
  // IDLE  | scanning disabled, all anodes and segments off
  // DRIVE | digit idx lit for REFRESH cycles
  // GAP   | all anodes off for BLANK cycles before the next digit

  localparam int CMAX = (REFRESH > BLANK) ? REFRESH : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(N_DIGITS);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [4*N_DIGITS-1:0] pend_value, disp_value;
  logic [N_DIGITS-1:0]   pend_dp, disp_dp;
  logic                  pend_flag;

  logic                  at_boundary, xfer;
  logic [3:0]            cur_digit;
  logic [N_DIGITS-1:0]   lz_mask;
  logic                  all_zero;
  logic [7:0]            seg_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: hex_glyph = 7'h7E;
      4'h1: hex_glyph = 7'h30;
      4'h2: hex_glyph = 7'h6D;
      4'h3: hex_glyph = 7'h79;
      4'h4: hex_glyph = 7'h33;
      4'h5: hex_glyph = 7'h5B;
      4'h6: hex_glyph = 7'h5F;
      4'h7: hex_glyph = 7'h70;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h7B;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h1F;
      4'hC: hex_glyph = 7'h4E;
      4'hD: hex_glyph = 7'h3D;
      4'hE: hex_glyph = 7'h4F;
      default: hex_glyph = 7'h47;
    endcase
  endfunction

  always_comb begin
    at_boundary = en && (state == GAP) && (cnt == CW'(BLANK - 1)) &&
                  (idx == IW'(N_DIGITS - 1));
    // Swap in the pending frame at a frame boundary or when leaving IDLE
    xfer = pend_flag && (at_boundary || (en && state == IDLE));

    // A digit is blanked when it and every digit above it are zero
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (disp_value[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_blank && all_zero;
    end

    cur_digit = disp_value[{idx, 2'b00} +: 4];
    seg_next  = {disp_dp[idx], lz_mask[idx] ? 7'h00 : hex_glyph(cur_digit)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
      end
      if (xfer) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
      end
      pend_flag <= load ? 1'b1 : (xfer ? 1'b0 : pend_flag);

      if (!en) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
        an    <= '0;
        seg   <= '0;
      end else begin
        an  <= (state == DRIVE) ? (N_DIGITS'(1) << idx) : '0;
        seg <= (state == DRIVE) ? seg_next : 8'h00;
        case (state)
          IDLE: begin
            state <= DRIVE;
            idx   <= '0;
            cnt   <= '0;
          end
          DRIVE: begin
            if (cnt == CW'(REFRESH - 1)) begin
              state <= GAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == CW'(BLANK - 1)) begin
              state <= DRIVE;
              cnt   <= '0;
              if (idx == IW'(N_DIGITS - 1)) begin
                idx        <= '0;
                frame_done <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with N_DIGITS=4, REFRESH=4, BLANK=1 (20-cycle frame).
// Each frame is checked cycle by cycle against hand-computed segment patterns.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        reset, en, load, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.N_DIGITS(4), .REFRESH(4), .BLANK(1)) dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .dp(dp), .load(load),
    .lz_blank(lz_blank), .seg(seg), .an(an), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    phase = (phase + 1) % 20;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"},  32'(an),         32'h0);
    check({tag, "_seg"}, 32'(seg),        32'h0);
    check({tag, "_fd"},  32'(frame_done), 32'h0);
  endtask

  // segs = {digit3, digit2, digit1, digit0} expected pabcdefg patterns
  task automatic check_phase(input string tag, input logic [31:0] segs);
    int   d;
    logic lit;
    logic [7:0] es;
    d   = phase / 5;
    lit = (phase % 5) < 4;
    es  = lit ? segs[d*8 +: 8] : 8'h00;
    check($sformatf("%s_p%0d_an", tag, phase),  32'(an),  lit ? (32'd1 << d) : 32'd0);
    check($sformatf("%s_p%0d_seg", tag, phase), 32'(seg), 32'(es));
    check($sformatf("%s_p%0d_fd", tag, phase),  32'(frame_done), (phase == 19) ? 32'd1 : 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] segs,
                           input int lp0, input logic [15:0] lv0,
                           input int lp1, input logic [15:0] lv1,
                           input int lp2, input logic [15:0] lv2,
                           input logic [3:0] ldp);
    for (int j = 0; j < 20; j++) begin
      check_phase(tag, segs);
      load = 1'b0;
      if (phase == lp0) begin value = lv0; dp = ldp; load = 1'b1; end
      if (phase == lp1) begin value = lv1; dp = ldp; load = 1'b1; end
      if (phase == lp2) begin value = lv2; dp = ldp; load = 1'b1; end
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
    value = '0; dp = '0;
    tick();
    tick();
    check_off("reset");
    reset = 1'b0;
    tick();
    check_off("idle");

    // Scanning starts: digit 0 appears one cycle after the enabling edge
    en = 1'b1;
    tick();
    check_off("start");
    tick();
    phase = 0;
    run_frame("t1a", 32'h7E7E7E7E, -1, 0, -1, 0, -1, 0, 4'h0);
    run_frame("t1b", 32'h7E7E7E7E, -1, 0, -1, 0, -1, 0, 4'h0);

    // Mid-frame load only shows from the next frame
    run_frame("t2a", 32'h7E7E7E7E, 7, 16'h1A8F, -1, 0, -1, 0, 4'b0100);
    run_frame("t2b", 32'h30F77F47, -1, 0, -1, 0, -1, 0, 4'h0);

    lz_blank = 1'b1;
    run_frame("t3a", 32'h30F77F47, 5, 16'h0070, -1, 0, -1, 0, 4'h0);
    run_frame("t3b", 32'h0000707E, 5, 16'h0000, -1, 0, -1, 0, 4'h0);
    run_frame("t3c", 32'h0000007E, -1, 0, -1, 0, -1, 0, 4'h0);
    lz_blank = 1'b0;

    // Two loads in one frame, third on the frame-boundary edge
    run_frame("t4a", 32'h7E7E7E7E, 3, 16'h1111, 8, 16'h2222, 18, 16'h3333, 4'h0);
    run_frame("t4b", 32'h6D6D6D6D, -1, 0, -1, 0, -1, 0, 4'h0);
    run_frame("t4c", 32'h79797979, -1, 0, -1, 0, -1, 0, 4'h0);

    // Drop en for three cycles while digit 2 is driven
    for (int j = 0; j < 12; j++) begin
      check_phase("t5a", 32'h79797979);
      if (j < 11) tick();
    end
    en = 1'b0;
    tick(); check_off("t5_off1");
    tick(); check_off("t5_off2");
    tick(); check_off("t5_off3");
    en = 1'b1;
    tick(); check_off("t5_restart");
    tick();
    phase = 0;
    run_frame("t5b", 32'h79797979, -1, 0, -1, 0, -1, 0, 4'h0);

    // Reset during a GAP with a load pending
    for (int j = 0; j < 4; j++) begin
      check_phase("t6a", 32'h79797979);
      load = 1'b0;
      if (j == 1) begin value = 16'h5555; dp = 4'hF; load = 1'b1; end
      if (j == 3) reset = 1'b1;
      tick();
    end
    load = 1'b0;
    check_off("t6_reset");
    reset = 1'b0;
    tick();
    check_off("t6_restart");
    tick();
    phase = 0;
    run_frame("t6b", 32'h7E7E7E7E, -1, 0, -1, 0, -1, 0, 4'h0);
    run_frame("t6c", 32'h7E7E7E7E, -1, 0, -1, 0, -1, 0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
